// File: rtl/router_fifo.sv
// Packet-aware output FIFO for one router port.
// Each entry keeps its header marker so the read side can track how much of the packet remains.
module router_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] data_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = WIDTH + 1;

    logic [WIDTH:0]   mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rd_entry;
    logic [CW-1:0]    hdr_len;
    logic             do_write;
    logic             do_read;

    // Extra MSB on each pointer distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign do_write = write_enb && !full && !soft_reset;
    assign do_read  = read_enb && !empty && !soft_reset;

    assign rd_entry = mem[rd_ptr[AW-1:0]];
    assign hdr_len  = CW'(rd_entry[WIDTH-1:2]) + CW'(1);

    always_ff @(posedge clock) begin
        if (do_write)
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn)
            wr_ptr <= '0;
        else if (soft_reset)
            wr_ptr <= '0;
        else if (do_write)
            wr_ptr <= wr_ptr + (AW+1)'(1);
    end

    // Header pops load the remaining-word count; once it drains, an idle cycle clears the output.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else if (soft_reset) begin
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else if (do_read) begin
            data_out <= rd_entry[WIDTH-1:0];
            rd_ptr   <= rd_ptr + (AW+1)'(1);
            if (rd_entry[WIDTH])
                count <= hdr_len;
            else if (count != '0)
                count <= count - CW'(1);
        end else if (count == '0) begin
            data_out <= '0;
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
// Inputs change just after rising edges; outputs are sampled on falling edges.
module tb_router_fifo;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [2:0] data_in;
    logic       full;
    logic       empty;
    logic [2:0] data_out;

    int checks = 0;
    int errors = 0;

    router_fifo #(.WIDTH(3), .DEPTH(16)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock cycle of stimulus; returns at the following falling edge with inputs idle.
    task automatic drive(input logic we, input logic re, input logic lfd,
                         input logic [2:0] d, input logic sr);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        data_in    = d;
        soft_reset = sr;
        @(posedge clock);
        #1;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 3'b000;
        soft_reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset;
        resetn = 1'b1;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", full); end
        checks++;
        if (data_out !== 3'b000) begin errors++; $display("[TB] FAIL reset_data got %b want 000", data_out); end
    endtask

    task automatic test_fill_and_read;
        logic [2:0] seq [16];
        seq[0] = 3'b101;
        for (int i = 1; i < 15; i++) seq[i] = 3'(i % 8);
        seq[15] = 3'b010;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, (i == 0), seq[i], 1'b0);
            if (i == 0) begin
                checks++;
                if (empty !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty_after_first got %b want 0", empty); end
            end
            if (i == 14) begin
                checks++;
                if (full !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_after_15 got %b want 0", full); end
            end
        end
        checks++;
        if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full_after_16 got %b want 1", full); end
        drive(1'b1, 1'b0, 1'b0, 3'b111, 1'b0);
        checks++;
        if (full !== 1'b1) begin errors++; $display("[TB] FAIL overflow_full got %b want 1", full); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
            checks++;
            if (data_out !== seq[i]) begin errors++; $display("[TB] FAIL readout_%0d got %b want %b", i, data_out, seq[i]); end
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL readout_empty got %b want 1", empty); end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b000) begin errors++; $display("[TB] FAIL readout_clear got %b want 000", data_out); end
    endtask

    task automatic test_packet_counter;
        drive(1'b1, 1'b0, 1'b1, 3'b101, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'b011, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'b110, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b101) begin errors++; $display("[TB] FAIL pkt_header got %b want 101", data_out); end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b101) begin errors++; $display("[TB] FAIL pkt_hold_count2 got %b want 101", data_out); end
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b011) begin errors++; $display("[TB] FAIL pkt_payload got %b want 011", data_out); end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b011) begin errors++; $display("[TB] FAIL pkt_hold_count1 got %b want 011", data_out); end
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b110) begin errors++; $display("[TB] FAIL pkt_parity got %b want 110", data_out); end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b000) begin errors++; $display("[TB] FAIL pkt_clear_count0 got %b want 000", data_out); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL pkt_empty got %b want 1", empty); end
    endtask

    task automatic test_simultaneous;
        logic [2:0] want;
        for (int i = 0; i < 16; i++)
            drive(1'b1, 1'b0, 1'b0, 3'((i + 3) % 7), 1'b0);
        drive(1'b1, 1'b1, 1'b0, 3'b111, 1'b0);
        checks++;
        if (data_out !== 3'b011) begin errors++; $display("[TB] FAIL simul_full_read got %b want 011", data_out); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("[TB] FAIL simul_full_drop got %b want 0", full); end
        for (int i = 1; i < 16; i++) begin
            want = 3'((i + 3) % 7);
            drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
            checks++;
            if (data_out !== want) begin errors++; $display("[TB] FAIL simul_drain_%0d got %b want %b", i, data_out, want); end
        end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL simul_drain_empty got %b want 1", empty); end
        drive(1'b1, 1'b0, 1'b0, 3'b100, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 3'b001, 1'b0);
        checks++;
        if (data_out !== 3'b100) begin errors++; $display("[TB] FAIL simul_one_read got %b want 100", data_out); end
        checks++;
        if (empty !== 1'b0) begin errors++; $display("[TB] FAIL simul_one_occupancy got %b want 0", empty); end
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b001) begin errors++; $display("[TB] FAIL simul_one_order got %b want 001", data_out); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL simul_one_empty got %b want 1", empty); end
    endtask

    task automatic test_soft_reset;
        drive(1'b1, 1'b0, 1'b1, 3'b101, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, 1'b0, 3'(i + 1), 1'b0);
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b101) begin errors++; $display("[TB] FAIL soft_pre_header got %b want 101", data_out); end
        drive(1'b1, 1'b1, 1'b0, 3'b110, 1'b1);
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL soft_empty got %b want 1", empty); end
        checks++;
        if (data_out !== 3'b000) begin errors++; $display("[TB] FAIL soft_data got %b want 000", data_out); end
        drive(1'b1, 1'b0, 1'b0, 3'b011, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b011) begin errors++; $display("[TB] FAIL soft_after_read got %b want 011", data_out); end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b000) begin errors++; $display("[TB] FAIL soft_count_cleared got %b want 000", data_out); end
    endtask

    task automatic test_async_reset;
        drive(1'b1, 1'b0, 1'b1, 3'b101, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'b010, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'b001, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        resetn = 1'b1;
        #1;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL async_empty got %b want 1", empty); end
        checks++;
        if (data_out !== 3'b000) begin errors++; $display("[TB] FAIL async_data got %b want 000", data_out); end
        @(negedge clock);
        resetn = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 3'b110, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
        checks++;
        if (data_out !== 3'b110) begin errors++; $display("[TB] FAIL async_reuse got %b want 110", data_out); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL async_reuse_empty got %b want 1", empty); end
    endtask

    initial begin
        resetn     = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 3'b000;
        test_reset();
        test_fill_and_read();
        test_packet_counter();
        test_simultaneous();
        test_soft_reset();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
# router_fifo

Packet-aware FIFO buffer for one output port of the router. Stores up to 16 words written by the router's synchronizer/FSM side and returns them in order to the read-side client. Each entry carries a header marker (`lfd_state`), so the FIFO tracks how many words of the current packet remain. The output is cleared once a packet has been fully read out.

## Interface
- `WIDTH`, 3: data word width in bits.
- `DEPTH`, 16: number of entries; must be a power of two.
- `clock` input 1: single clock; all state updates on the rising edge.
- `resetn` input 1: asynchronous reset, active-high. Clears all state.
- `soft_reset` input 1: synchronous, active-high flush, e.g. on packet timeout.
- `write_enb` input 1: write request.
- `read_enb` input 1: read request.
- `lfd_state` input 1: high while `data_in` is a packet header word; stored with the word.
- `data_in` input WIDTH: write data.
- `full` output 1: combinational; DEPTH entries stored.
- `empty` output 1: combinational; zero entries stored.
- `data_out` output WIDTH: registered read data.

## Operation
- Storage is DEPTH x (WIDTH+1).
  - Entry bit WIDTH holds `lfd_state` at write time.
  - Entry bits WIDTH-1:0 hold `data_in`.
- Write and read pointers are log2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = low bits equal and MSBs differ.
- Write accepted when `write_enb` && !`full`: store {`lfd_state`, `data_in`} at the write pointer, then increment it. Write while full is dropped; no state changes.
- Read accepted when `read_enb` && !`empty`: `data_out` <= stored data at the read pointer; increment the read pointer. Read while empty is ignored.
- Simultaneous write and read in the same cycle are independent.
  - When full, the read proceeds and the write is dropped.
  - When empty, the write proceeds and the read is ignored.
  - Occupancy is otherwise unchanged.
- Packet counter `count`, internal, width WIDTH+1, reset 0. Updated on an accepted read:
  - Popped entry has header bit set: `count` <= `data[WIDTH-1:2]` + 1. This is the payload length plus parity, i.e. the words still to follow.
  - Non-header entry with `count` != 0: `count` <= `count` - 1.
  - Non-header entry with `count` = 0: `count` stays 0.
- Output clear: if no read is accepted and `count` = 0, `data_out` <= 0. Otherwise `data_out` holds its value.
- `soft_reset` (sync) takes priority over read and write. It clears both pointers, `count`, and `data_out`, and invalidates all entries. Memory contents need not be zeroed.
- `resetn` (async) has the same effect as `soft_reset`, applied immediately.

## Timing
- Output values under reset: `full` = 0, `empty` = 1, `data_out` = 0.
- Write to flags: `empty` falls in the cycle after the first accepted write edge. `full` rises right after the DEPTH-th accepted write.
- Read latency is 1 cycle: data appears on `data_out` after the clock edge that accepts the read.
- Flags update combinationally from the pointers.
- Wrap-around: pointers wrap modulo 2*DEPTH, so flags stay correct across any number of wraps.
- Reset asserted mid-packet: all stored words are discarded and the FIFO is usable on the next edge after release.

## Test plan
- Reset values: assert `resetn` high for 1 cycle, then deassert -> `empty` = 1, `full` = 0, `data_out` = 0.
- Fill to full:
  - Stimulus: 16 writes; header 3'b101 with `lfd_state` = 1, then 14 payload words, then parity.
  - Required: `empty` = 0 after the first write; `full` = 1 after the 16th.
  - A 17th write with `data_in` = 3'b111 is dropped, and the read-back order is unchanged.
- Read-out:
  - Stimulus: after the fill, hold `read_enb` = 1 for 16 cycles.
  - Required: `data_out` reproduces the written sequence with 1-cycle latency, and `empty` = 1 after the 16th read.
  - After `read_enb` drops, with `count` = 0, `data_out` returns to 0.
- Packet counter (header 3'b101, then 2 words):
  - Reading the header sets `count` = 2.
  - Each following read decrements `count`, reaching 0 after the parity word.
- Simultaneous read and write:
  - When full, `read_enb` = `write_enb` = 1 -> the read succeeds and the write is dropped.
  - With 1 entry stored -> occupancy stays 1 and the order is preserved.
- Soft reset mid-packet: write 5 words, pulse `soft_reset` for 1 cycle -> `empty` = 1 and `data_out` = 0 next edge. A subsequent write/read of 3'b011 returns 3'b011.
